// File: rtl/uart_tx.sv
// uart_tx: byte FIFO feeding an 8N1 UART serialiser on the CPU write port.
// Ports: clk, reset (async high), w_req/w_data in, w_busy/tx/overflow out.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       w_req,
  input  logic [7:0] w_data,
  output logic       w_busy,
  output logic       tx,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BLAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;

  logic full, empty, push, pop, tick;

  assign full  = (cnt_q == FULL);
  assign empty = (cnt_q == '0);
  // acceptance is judged on the pre-pop count
  assign push  = w_req & ~full;
  assign tick  = (baud_q == BLAST);

  assign w_busy   = full;
  assign tx       = tx_q;
  assign overflow = ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // tx_d is the line level for the next cycle, so tx stays a flop
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = mem_q[rptr_q];
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = sh_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (tick) begin
          baud_d = '0;
          // chain straight into the next start bit when data waits
          if (!empty) begin
            pop     = 1'b1;
            sh_d    = mem_q[rptr_q];
            bit_d   = '0;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= w_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      if (w_req && full) ovf_q <= 1'b1;
    end
  end

endmodule
